// File: rtl/if_id_fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : if_id_fetch_queue_pkg                                             |
// | Brief  : Shared constants and the fetch-entry type for the IF/ID queue.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package if_id_fetch_queue_pkg;

  localparam int WORD     = 32;
  localparam int FQ_DEPTH = 4;

  // Also consumed directly by the decode-stage input.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_id_fetch_queue_storage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fq_storage                                                        |
// | Brief  : DEPTH x WIDTH register array, one sync write, one async read.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fq_storage
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = 2,
  parameter int WIDTH = $bits(fetch_entry_t)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  // Data words carry no reset; occupancy is tracked by the controller.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : if_id_fetch_queue                                                 |
// | Brief  : IF->ID decoupling FIFO, show-ahead read, single-cycle flush.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module if_id_fetch_queue #(
  parameter int DEPTH = if_id_fetch_queue_pkg::FQ_DEPTH,
  parameter int PTR_W = 2,
  parameter int WORD  = if_id_fetch_queue_pkg::WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WORD-1:0]  in_pc,
  input  logic [WORD-1:0]  in_inst,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WORD-1:0]  out_pc,
  output logic [WORD-1:0]  out_inst,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  import if_id_fetch_queue_pkg::*;

  localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);
  localparam int             c_ew   = 2 * WORD;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;
  logic [c_ew-1:0]  w_rdata;

  // Status comes only from registered count, so in_ready never sees out_ready.
  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid  & in_ready  & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  fq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (c_ew)
  ) u_storage (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata ({in_pc, in_inst}),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Empty queue presents a zeroed bubble instead of stale storage.
  assign out_pc   = out_valid ? w_rdata[c_ew-1:WORD] : '0;
  assign out_inst = out_valid ? w_rdata[WORD-1:0]    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_if_id_fetch_queue                                              |
// | Brief  : Directed + random scoreboard bench for if_id_fetch_queue.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_if_id_fetch_queue;

  import if_id_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [WORD-1:0] in_pc = '0;
  logic [WORD-1:0] in_inst = '0;
  logic            in_ready;
  logic            out_valid;
  logic [WORD-1:0] out_pc;
  logic [WORD-1:0] out_inst;
  logic            out_ready = 1'b0;
  logic [PTR_W:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected queue contents, oldest first.
  fetch_entry_t model[$];
  fetch_entry_t new_e;
  int           sz;
  bit           acc;
  bit           take;

  if_id_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WORD(WORD)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Monitor: compare outputs to the model mid-cycle, then apply the accepted traffic.
  always @(negedge clk) begin
    if (!rst) begin
      model.delete();
      check("reset_count", 64'(count), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
    end else begin
      sz = model.size();
      check("count", 64'(count), 64'(sz));
      check("out_valid", 64'(out_valid), 64'(sz != 0));
      check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
      if (sz > 0) begin
        check("head_pc", 64'(out_pc), 64'(model[0].pc));
        check("head_inst", 64'(out_inst), 64'(model[0].inst));
      end else begin
        check("bubble_pc", 64'(out_pc), 64'd0);
        check("bubble_inst", 64'(out_inst), 64'd0);
      end
      if (flush) begin
        model.delete();
      end else begin
        acc  = in_valid && (sz < DEPTH);
        take = out_ready && (sz > 0);
        new_e.pc   = in_pc;
        new_e.inst = in_inst;
        if (take) void'(model.pop_front());
        if (acc)  model.push_back(new_e);
      end
    end
  end

  initial begin
    #12 rst = 1'b1;

    // Three pushes with decode frozen.
    drive(1, 32'h4, 32'hA0, 0, 0);
    drive(1, 32'h8, 32'hA1, 0, 0);
    drive(1, 32'hC, 32'hA2, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("p1_count", 64'(count), 64'd3);
    check("p1_out_pc", 64'(out_pc), 64'h4);
    check("p1_out_inst", 64'(out_inst), 64'hA0);
    check("p1_in_ready", 64'(in_ready), 64'd1);

    // Fill, then hold a refused entry while full.
    drive(1, 32'h10, 32'hA3, 0, 0);
    drive(1, 32'h14, 32'hA4, 0, 0);
    drive(1, 32'h14, 32'hA4, 0, 0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    drive(1, 32'h14, 32'hA4, 1, 0);
    drive(0, 0, 0, 0, 0);
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
    check("drain_count", 64'(count), 64'd0);

    // Streaming push+pop across pointer wrap.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 32'(4 * i), 32'(32'hB0 + i), 1, 0);
      if (i > 1) check("stream_count", 64'(count), 64'd1);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);

    // Flush with a same-cycle push.
    drive(1, 32'h40, 32'hC0, 0, 0);
    drive(1, 32'h44, 32'hC1, 0, 0);
    drive(1, 32'h48, 32'hC2, 0, 0);
    drive(1, 32'h100, 32'hDEAD, 0, 1);
    drive(0, 0, 0, 1, 0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_pc", 64'(out_pc), 64'd0);
    check("flush_out_inst", 64'(out_inst), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges.
    drive(1, 32'h50, 32'hE0, 0, 0);
    drive(1, 32'h54, 32'hE1, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("pre_rst_count", 64'(count), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    #4 rst = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Empty queue with decode ready.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 0);
      check("empty_count", 64'(count), 64'd0);
      check("empty_out_valid", 64'(out_valid), 64'd0);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 0);
    check("final_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
